// File: rtl/dht11_pkg.sv
// Shared types, timing defaults and helpers for the DHT11 polling controller.
package dht11_pkg;

  typedef enum logic [2:0] {
    StPowerup  = 3'd0,
    StIdle     = 3'd1,
    StStart    = 3'd2,
    StWaitResp = 3'd3,
    StGap      = 3'd4
  } state_e;

  localparam int unsigned TimerW        = 12;
  localparam int unsigned PowerupMsDef  = 1000;
  localparam int unsigned PeriodMsDef   = 2000;
  localparam int unsigned TimeoutMsDef  = 100;
  localparam int unsigned MaxRetryDef   = 3;
  localparam int unsigned RetryGapMsDef = 1100;
  localparam int unsigned MaxStepDef    = 10;

  function automatic logic [7:0] abs_diff8(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/ms_down_timer.sv
// Loadable millisecond down-counter; expired_o is high while the count sits at zero.
module ms_down_timer
  import dht11_pkg::*;
#(
  parameter logic [TimerW-1:0] ResetVal = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_i,
  input  logic              load_i,
  input  logic [TimerW-1:0] load_val_i,
  output logic              expired_o
);

  logic [TimerW-1:0] cnt_d, cnt_q;

  // A load wins over a coincident tick.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TimerW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= ResetVal;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/dht11_poll_ctrl.sv
// Periodic/manual DHT11 poll scheduler with timeout, retry and last-good latching.
// Optional spike rejection is built when DHT11_SPIKE_REJECT_EN is defined.
module dht11_poll_ctrl
  import dht11_pkg::*;
#(
  parameter int unsigned PowerupMs  = PowerupMsDef,
  parameter int unsigned PeriodMs   = PeriodMsDef,
  parameter int unsigned TimeoutMs  = TimeoutMsDef,
  parameter int unsigned MaxRetry   = MaxRetryDef,
  parameter int unsigned RetryGapMs = RetryGapMsDef,
  parameter int unsigned MaxStep    = MaxStepDef
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_ms_i,
  input  logic       enable_i,
  input  logic       manual_start_i,
  output logic       drv_start_o,
  input  logic       drv_done_i,
  input  logic       drv_err_i,
  input  logic [7:0] drv_humid_i,
  input  logic [7:0] drv_temp_i,
  output logic [7:0] humid_out_o,
  output logic [7:0] temp_out_o,
  output logic       valid_o,
  output logic       stale_o,
  output logic [7:0] err_count_o,
  output logic       busy_o
);

  localparam logic [TimerW-1:0] PowerupVal  = TimerW'(PowerupMs);
  localparam logic [TimerW-1:0] PeriodVal   = TimerW'(PeriodMs);
  localparam logic [TimerW-1:0] TimeoutVal  = TimerW'(TimeoutMs);
  localparam logic [TimerW-1:0] RetryGapVal = TimerW'(RetryGapMs);
  localparam logic [2:0]        RetryMax    = 3'(MaxRetry);

  state_e            state_d, state_q;
  logic [2:0]        retry_d, retry_q;
  logic [7:0]        humid_d, humid_q;
  logic [7:0]        temp_d, temp_q;
  logic              valid_d, valid_q;
  logic              stale_d, stale_q;
  logic [7:0]        err_cnt_d, err_cnt_q;
  logic              phase_load, phase_exp;
  logic [TimerW-1:0] phase_val;
  logic              period_load, period_exp;
  logic              accept, fail;
  logic [2:0]        retry_inc;

  ms_down_timer #(
    .ResetVal (PowerupVal)
  ) u_phase_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_i     (tick_ms_i),
    .load_i     (phase_load),
    .load_val_i (phase_val),
    .expired_o  (phase_exp)
  );

  // Period timer resets to zero so the first poll after power-up is immediate.
  ms_down_timer #(
    .ResetVal ('0)
  ) u_period_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_i     (tick_ms_i),
    .load_i     (period_load),
    .load_val_i (PeriodVal),
    .expired_o  (period_exp)
  );

  assign retry_inc = retry_q + 3'd1;

`ifdef DHT11_SPIKE_REJECT_EN
  localparam logic [7:0] MaxStepVal = 8'(MaxStep);
  logic spike;
  // The last attempt of a cycle always accepts so real steps are not locked out.
  assign spike = valid_q && (retry_inc < RetryMax) &&
                 ((abs_diff8(drv_humid_i, humid_q) > MaxStepVal) ||
                  (abs_diff8(drv_temp_i, temp_q) > MaxStepVal));
`else
  logic spike;
  logic unused_max_step;
  assign spike           = 1'b0;
  assign unused_max_step = ^MaxStep;
`endif

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    humid_d     = humid_q;
    temp_d      = temp_q;
    valid_d     = valid_q;
    stale_d     = stale_q;
    err_cnt_d   = err_cnt_q;
    phase_load  = 1'b0;
    phase_val   = TimeoutVal;
    period_load = 1'b0;
    accept      = 1'b0;
    fail        = 1'b0;

    unique case (state_q)
      StPowerup: begin
        if (phase_exp) state_d = StIdle;
      end
      StIdle: begin
        if (manual_start_i || (period_exp && enable_i)) state_d = StStart;
      end
      StStart: begin
        phase_load  = 1'b1;
        phase_val   = TimeoutVal;
        period_load = (retry_q == 3'd0);
        state_d     = StWaitResp;
      end
      StWaitResp: begin
        if (drv_err_i) begin
          fail = 1'b1;
        end else if (drv_done_i) begin
          fail   = spike;
          accept = !spike;
        end else if (phase_exp) begin
          fail = 1'b1;
        end
      end
      StGap: begin
        if (phase_exp) state_d = StStart;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      humid_d = drv_humid_i;
      temp_d  = drv_temp_i;
      valid_d = 1'b1;
      stale_d = 1'b0;
      retry_d = 3'd0;
      state_d = StIdle;
    end

    if (fail) begin
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      if (retry_inc < RetryMax) begin
        retry_d    = retry_inc;
        phase_load = 1'b1;
        phase_val  = RetryGapVal;
        state_d    = StGap;
      end else begin
        stale_d = 1'b1;
        retry_d = 3'd0;
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StPowerup;
      retry_q   <= 3'd0;
      humid_q   <= 8'd0;
      temp_q    <= 8'd0;
      valid_q   <= 1'b0;
      stale_q   <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      retry_q   <= retry_d;
      humid_q   <= humid_d;
      temp_q    <= temp_d;
      valid_q   <= valid_d;
      stale_q   <= stale_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Decoded straight from state so reset drops the pulse without waiting for a clock.
  assign drv_start_o = (state_q == StStart);
  assign busy_o      = (state_q == StStart) || (state_q == StWaitResp) || (state_q == StGap);
  assign humid_out_o = humid_q;
  assign temp_out_o  = temp_q;
  assign valid_o     = valid_q;
  assign stale_o     = stale_q;
  assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_dht11_poll_ctrl.sv
// Directed bench for dht11_poll_ctrl; one tick_ms every 10 clocks, short sim timings.
module tb_dht11_poll_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_ms = 1'b0;
  logic       enable = 1'b0;
  logic       manual_start = 1'b0;
  logic       drv_done = 1'b0;
  logic       drv_err = 1'b0;
  logic [7:0] drv_humid = 8'd0;
  logic [7:0] drv_temp = 8'd0;
  logic       drv_start;
  logic [7:0] humid_out, temp_out, err_count;
  logic       valid, stale, busy;

  int total = 0;
  int bad = 0;
  int ms_cnt = 0;
  int start_cnt = 0;
  int t_ms;

  always #5 clk = ~clk;

  dht11_poll_ctrl #(
    .PowerupMs  (10),
    .PeriodMs   (20),
    .TimeoutMs  (5),
    .MaxRetry   (3),
    .RetryGapMs (4),
    .MaxStep    (10)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tick_ms_i      (tick_ms),
    .enable_i       (enable),
    .manual_start_i (manual_start),
    .drv_start_o    (drv_start),
    .drv_done_i     (drv_done),
    .drv_err_i      (drv_err),
    .drv_humid_i    (drv_humid),
    .drv_temp_i     (drv_temp),
    .humid_out_o    (humid_out),
    .temp_out_o     (temp_out),
    .valid_o        (valid),
    .stale_o        (stale),
    .err_count_o    (err_count),
    .busy_o         (busy)
  );

  // ms_cnt holds the number of the tick currently raised or last consumed.
  initial begin : tick_gen
    wait (rst_n);
    forever begin
      repeat (9) @(posedge clk);
      #2 tick_ms = 1'b1;
      ms_cnt++;
      @(posedge clk);
      #2 tick_ms = 1'b0;
    end
  end

  initial begin : start_mon
    forever begin
      @(posedge clk);
      if (drv_start === 1'b1) start_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag, output int at_ms);
    int n = 0;
    @(negedge clk);
    while (drv_start !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    at_ms = ms_cnt;
    chk({tag, "_seen"}, {31'd0, drv_start}, 32'd1);
  endtask

  task automatic pulse(input logic done, input logic err, input logic [7:0] h,
                       input logic [7:0] t);
    @(negedge clk);
    drv_done  = done;
    drv_err   = err;
    drv_humid = h;
    drv_temp  = t;
    @(negedge clk);
    drv_done = 1'b0;
    drv_err  = 1'b0;
  endtask

  task automatic wait_ms(input int n);
    while (ms_cnt < n) @(negedge clk);
  endtask

  initial begin : main
    repeat (3) @(negedge clk);
    chk("rst_drv_start", drv_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_stale", stale, 0);
    chk("rst_err", err_count, 0);
    chk("rst_humid", humid_out, 0);
    chk("rst_temp", temp_out, 0);

    enable = 1'b1;
    rst_n  = 1'b1;

    // Power-up then first poll, answered 2 ms later.
    wait_start("start1", t_ms);
    chk("start1_ms", t_ms, 10);
    chk("start1_busy", busy, 1);
    @(negedge clk);
    chk("start1_width", drv_start, 0);
    wait_ms(12);
    pulse(1'b1, 1'b0, 8'd45, 8'd23);
    chk("ok1_humid", humid_out, 45);
    chk("ok1_temp", temp_out, 23);
    chk("ok1_valid", valid, 1);
    chk("ok1_stale", stale, 0);
    chk("ok1_idle", busy, 0);
    wait_start("start2", t_ms);
    chk("start2_ms", t_ms, 30);

    // Silent driver: timeout 5 + gap 4 per retry; cycle overruns the 20 ms period.
    wait_start("retry1", t_ms);
    chk("retry1_ms", t_ms, 39);
    wait_start("retry2", t_ms);
    chk("retry2_ms", t_ms, 48);
    wait_start("overrun_start", t_ms);
    chk("overrun_start_ms", t_ms, 53);
    chk("silent_err", err_count, 3);
    chk("silent_stale", stale, 1);
    chk("silent_humid_hold", humid_out, 45);
    chk("silent_temp_hold", temp_out, 23);

    // Error then success on the retry.
    pulse(1'b0, 1'b1, 8'd0, 8'd0);
    wait_start("errretry", t_ms);
    chk("errretry_ms", t_ms, 57);
    wait_ms(58);
    pulse(1'b1, 1'b0, 8'd50, 8'd25);
    chk("recover_err", err_count, 4);
    chk("recover_stale", stale, 0);
    chk("recover_humid", humid_out, 50);
    chk("recover_temp", temp_out, 25);

    // done and err together count as an error.
    wait_start("start_both", t_ms);
    chk("start_both_ms", t_ms, 73);
    pulse(1'b1, 1'b1, 8'd99, 8'd99);
    chk("both_humid_hold", humid_out, 50);
    chk("both_temp_hold", temp_out, 25);
    chk("both_err", err_count, 5);
    wait_start("both_retry", t_ms);
    chk("both_retry_ms", t_ms, 77);
    enable = 1'b0;
    pulse(1'b1, 1'b0, 8'd51, 8'd26);
    chk("both_retry_humid", humid_out, 51);

    // Disabled: period expires at 93 but nothing starts.
    wait_ms(96);
    chk("disabled_no_start", start_cnt, 8);
    chk("disabled_idle", busy, 0);
    manual_start = 1'b1;
    @(negedge clk);
    manual_start = 1'b0;
    chk("manual_latency", drv_start, 1);
    @(negedge clk);
    chk("manual_width", drv_start, 0);
    manual_start = 1'b1;
    @(negedge clk);
    manual_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("manual_in_wait_ignored", start_cnt, 9);
    pulse(1'b1, 1'b0, 8'd52, 8'd27);
    chk("manual_humid", humid_out, 52);
    chk("manual_temp", temp_out, 27);

    // Expired and held; raising enable starts on the next clock.
    wait_ms(118);
    chk("held_no_start", start_cnt, 9);
    enable = 1'b1;
    @(negedge clk);
    chk("enable_rise_start", drv_start, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_drv_start", drv_start, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_humid", humid_out, 0);
    chk("async_rst_valid", valid, 0);
    chk("async_rst_err", err_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef DHT11_SPIKE_REJECT_EN
    wait_start("spk0", t_ms);
    pulse(1'b1, 1'b0, 8'd40, 8'd20);
    chk("spk_base", humid_out, 40);
    wait_start("spk1", t_ms);
    pulse(1'b1, 1'b0, 8'd60, 8'd20);
    chk("spk_reject1", humid_out, 40);
    wait_start("spk2", t_ms);
    pulse(1'b1, 1'b0, 8'd60, 8'd20);
    wait_start("spk3", t_ms);
    pulse(1'b1, 1'b0, 8'd60, 8'd20);
    chk("spk_err", err_count, 2);
    chk("spk_stale", stale, 0);
    chk("spk_accept", humid_out, 60);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
